// File: rtl/pmem_arbiter_pkg.sv
// rtl/pmem_arbiter_pkg.sv - shared widths and arbiter state encoding for the pmem path
package pmem_arbiter_pkg;

    localparam int ADDR_W = 16;
    localparam int LINE_W = 128;

    typedef logic [2:0] arb_state_t;

    localparam arb_state_t IDLE   = 3'd0;
    localparam arb_state_t BUSY_A = 3'd1;
    localparam arb_state_t BUSY_B = 3'd2;
    localparam arb_state_t RESP_A = 3'd3;
    localparam arb_state_t RESP_B = 3'd4;

    // last_grant encoding: the port that won the most recent arbitration
    localparam logic GRANT_A = 1'b0;
    localparam logic GRANT_B = 1'b1;

endpackage

// File: rtl/pmem_arbiter_if.sv
// rtl/pmem_arbiter_if.sv - cache-side and memory-side signal bundle of the pmem arbiter
interface pmem_arbiter_if;
    import pmem_arbiter_pkg::*;

    logic              pmem_read_a;
    logic              pmem_write_a;
    logic [ADDR_W-1:0] pmem_address_a;
    logic [LINE_W-1:0] pmem_wdata_a;
    logic              pmem_resp_a;
    logic [LINE_W-1:0] pmem_rdata_a;

    logic              pmem_read_b;
    logic              pmem_write_b;
    logic [ADDR_W-1:0] pmem_address_b;
    logic [LINE_W-1:0] pmem_wdata_b;
    logic              pmem_resp_b;
    logic [LINE_W-1:0] pmem_rdata_b;

    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_address;
    logic [LINE_W-1:0] mem_wdata;
    logic              mem_resp;
    logic [LINE_W-1:0] mem_rdata;

    // slave: the arbiter's view; master: the caches plus physical memory around it
    modport slave (
        input  pmem_read_a, pmem_write_a, pmem_address_a, pmem_wdata_a,
        output pmem_resp_a, pmem_rdata_a,
        input  pmem_read_b, pmem_write_b, pmem_address_b, pmem_wdata_b,
        output pmem_resp_b, pmem_rdata_b,
        output mem_read, mem_write, mem_address, mem_wdata,
        input  mem_resp, mem_rdata
    );

    modport master (
        output pmem_read_a, pmem_write_a, pmem_address_a, pmem_wdata_a,
        input  pmem_resp_a, pmem_rdata_a,
        output pmem_read_b, pmem_write_b, pmem_address_b, pmem_wdata_b,
        input  pmem_resp_b, pmem_rdata_b,
        input  mem_read, mem_write, mem_address, mem_wdata,
        output mem_resp, mem_rdata
    );

endinterface

// File: rtl/pmem_arbiter.sv
// rtl/pmem_arbiter.sv - round-robin 2:1 arbiter from split L1 caches onto single-ported memory
module pmem_arbiter
    import pmem_arbiter_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    pmem_arbiter_if.slave   bus
);

    arb_state_t        state, state_d;
    logic              last_grant, last_grant_d;
    logic              op_wr, op_wr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LINE_W-1:0] wdata_q, wdata_d;
    logic [LINE_W-1:0] rdata_q, rdata_d;
    logic              req_a, req_b;

    assign req_a = bus.pmem_read_a | bus.pmem_write_a;
    assign req_b = bus.pmem_read_b | bus.pmem_write_b;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= GRANT_B;
            op_wr      <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
        end else begin
            state      <= state_d;
            last_grant <= last_grant_d;
            op_wr      <= op_wr_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
        end
    end

    // All outputs decode from flops only, so reset clears them without waiting for a clock.
    always_comb begin
        state_d          = state;
        last_grant_d     = last_grant;
        op_wr_d          = op_wr;
        addr_d           = addr_q;
        wdata_d          = wdata_q;
        rdata_d          = rdata_q;
        bus.mem_read     = 1'b0;
        bus.mem_write    = 1'b0;
        bus.mem_address  = addr_q;
        bus.mem_wdata    = wdata_q;
        bus.pmem_resp_a  = 1'b0;
        bus.pmem_resp_b  = 1'b0;
        bus.pmem_rdata_a = rdata_q;
        bus.pmem_rdata_b = rdata_q;

        case (state)
            IDLE: begin
                // a wins a tie only when b took the previous grant
                if (req_a && (!req_b || last_grant == GRANT_B)) begin
                    state_d      = BUSY_A;
                    last_grant_d = GRANT_A;
                    addr_d       = bus.pmem_address_a;
                    wdata_d      = bus.pmem_wdata_a;
                    op_wr_d      = bus.pmem_write_a;
                end else if (req_b) begin
                    state_d      = BUSY_B;
                    last_grant_d = GRANT_B;
                    addr_d       = bus.pmem_address_b;
                    wdata_d      = bus.pmem_wdata_b;
                    op_wr_d      = bus.pmem_write_b;
                end
            end
            BUSY_A, BUSY_B: begin
                bus.mem_read  = ~op_wr;
                bus.mem_write = op_wr;
                if (bus.mem_resp) begin
                    rdata_d = bus.mem_rdata;
                    state_d = (state == BUSY_A) ? RESP_A : RESP_B;
                end
            end
            RESP_A: begin
                bus.pmem_resp_a = 1'b1;
                state_d         = IDLE;
            end
            RESP_B: begin
                bus.pmem_resp_b = 1'b1;
                state_d         = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_pmem_arbiter.sv
// tb/tb_pmem_arbiter.sv - directed self-checking bench for pmem_arbiter
module tb_pmem_arbiter;
    import pmem_arbiter_pkg::*;

    typedef struct {
        logic        wr;
        logic [15:0] addr;
        logic [127:0] wdata;
    } txn_t;

    localparam logic [127:0] DEAD = 128'hDEADBEEF_01234567_89ABCDEF_DEADBEEF;
    localparam logic [127:0] DB   = 128'hB0B0B0B0_11112222_33334444_55556666;
    localparam logic [127:0] DC   = 128'hC0DEC0DE_77778888_9999AAAA_BBBBCCCC;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pmem_arbiter_if bus();

    pmem_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int mem_wait = 0;
    int mem_cnt  = 0;
    logic prev_a = 1'b0;
    logic prev_b = 1'b0;
    logic [127:0] mem_model [logic [15:0]];
    txn_t log_q[$];

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] pat(input logic [15:0] a);
        return {8{a ^ 16'hA5C3}};
    endfunction

    function automatic logic [127:0] rd(input logic [15:0] a);
        if (mem_model.exists(a)) return mem_model[a];
        return pat(a);
    endfunction

    // memory model: answers after mem_wait cycles, one-cycle mem_resp
    initial begin
        bus.mem_resp  = 1'b0;
        bus.mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (bus.mem_resp) begin
                bus.mem_resp = 1'b0;
                mem_cnt      = 0;
            end else if (bus.mem_read || bus.mem_write) begin
                if (mem_cnt >= mem_wait) begin
                    bus.mem_resp  = 1'b1;
                    bus.mem_rdata = rd(bus.mem_address);
                    if (bus.mem_write) mem_model[bus.mem_address] = bus.mem_wdata;
                    log_q.push_back('{bus.mem_write, bus.mem_address, bus.mem_wdata});
                end else begin
                    mem_cnt++;
                end
            end else begin
                mem_cnt = 0;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (prev_a) check("resp_a_width", 128'(bus.pmem_resp_a), 128'(0));
            if (prev_b) check("resp_b_width", 128'(bus.pmem_resp_b), 128'(0));
            if (bus.pmem_resp_a || bus.pmem_resp_b) begin
                check("strobe_in_resp", 128'({bus.mem_read, bus.mem_write}), 128'(0));
                check("dual_resp", 128'(bus.pmem_resp_a & bus.pmem_resp_b), 128'(0));
            end
            prev_a = bus.pmem_resp_a;
            prev_b = bus.pmem_resp_b;
        end
    end

    task automatic wait_resp(input int max_cyc, output logic ra, output logic rb,
                             output logic [127:0] rdv, output int cyc);
        ra = 1'b0; rb = 1'b0; rdv = '0; cyc = 0;
        for (int i = 1; i <= max_cyc && cyc == 0; i++) begin
            @(negedge clk);
            if (bus.pmem_resp_a || bus.pmem_resp_b) begin
                ra  = bus.pmem_resp_a;
                rb  = bus.pmem_resp_b;
                rdv = bus.pmem_resp_a ? bus.pmem_rdata_a : bus.pmem_rdata_b;
                cyc = i;
            end
        end
        if (cyc == 0) check("resp_timeout", 128'(0), 128'(1));
    endtask

    task automatic check_log(input string tag, input logic wr, input logic [15:0] addr,
                             input logic chk_wdata, input logic [127:0] wdata);
        txn_t t;
        if (log_q.size() == 0) begin
            check({tag, "_log_empty"}, 128'(0), 128'(1));
        end else begin
            t = log_q.pop_front();
            check({tag, "_wr"}, 128'(t.wr), 128'(wr));
            check({tag, "_addr"}, 128'(t.addr), 128'(addr));
            if (chk_wdata) check({tag, "_wdata"}, t.wdata, wdata);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_mem_read"}, 128'(bus.mem_read), 128'(0));
        check({tag, "_mem_write"}, 128'(bus.mem_write), 128'(0));
        check({tag, "_mem_address"}, 128'(bus.mem_address), 128'(0));
        check({tag, "_mem_wdata"}, bus.mem_wdata, 128'(0));
        check({tag, "_resp_a"}, 128'(bus.pmem_resp_a), 128'(0));
        check({tag, "_resp_b"}, 128'(bus.pmem_resp_b), 128'(0));
        check({tag, "_rdata_a"}, bus.pmem_rdata_a, 128'(0));
        check({tag, "_rdata_b"}, bus.pmem_rdata_b, 128'(0));
    endtask

    initial begin
        logic ra, rb;
        logic [127:0] rdv, exp_d;
        int cyc;
        logic exp_b;

        rst = 1'b1;
        bus.pmem_read_a = 1'b0; bus.pmem_write_a = 1'b0;
        bus.pmem_address_a = '0; bus.pmem_wdata_a = '0;
        bus.pmem_read_b = 1'b0; bus.pmem_write_b = 1'b0;
        bus.pmem_address_b = '0; bus.pmem_wdata_b = '0;
        mem_model[16'h0040] = DEAD;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        rst = 1'b0;

        // single read on a with two memory wait cycles
        mem_wait = 2;
        bus.pmem_read_a = 1'b1; bus.pmem_address_a = 16'h0040;
        @(negedge clk);
        check("t1_mem_read", 128'(bus.mem_read), 128'(1));
        check("t1_mem_write", 128'(bus.mem_write), 128'(0));
        check("t1_mem_address", 128'(bus.mem_address), 128'(16'h0040));
        wait_resp(10, ra, rb, rdv, cyc);
        check("t1_latency", 128'(cyc), 128'(3));
        check("t1_resp_a", 128'(ra), 128'(1));
        check("t1_resp_b", 128'(rb), 128'(0));
        check("t1_rdata", rdv, DEAD);
        check("t1_rdata_b_shared", bus.pmem_rdata_b, DEAD);
        bus.pmem_read_a = 1'b0;
        check_log("t1", 1'b0, 16'h0040, 1'b0, '0);

        // from reset: continuous tie a read / b write, 20 zero-wait transactions
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        log_q.delete();
        mem_wait = 0;
        bus.pmem_read_a = 1'b1;  bus.pmem_address_a = 16'h0100;
        bus.pmem_write_b = 1'b1; bus.pmem_address_b = 16'h0200; bus.pmem_wdata_b = DB;
        for (int t = 0; t < 20; t++) begin
            exp_b = t[0];
            wait_resp(8, ra, rb, rdv, cyc);
            check($sformatf("alt%0d_port", t), 128'({ra, rb}), exp_b ? 128'(2'b01) : 128'(2'b10));
            check($sformatf("alt%0d_gap", t), 128'(cyc), (t == 0) ? 128'(2) : 128'(3));
            if (!exp_b)       exp_d = pat(16'h0100);
            else if (t == 1)  exp_d = pat(16'h0200);
            else              exp_d = DB;
            check($sformatf("alt%0d_rdata", t), rdv, exp_d);
            check_log($sformatf("alt%0d", t), exp_b, exp_b ? 16'h0200 : 16'h0100, exp_b, DB);
        end
        bus.pmem_read_a = 1'b0;
        bus.pmem_write_b = 1'b0;

        // read and write together on b count as a write
        mem_wait = 1;
        bus.pmem_read_b = 1'b1; bus.pmem_write_b = 1'b1;
        bus.pmem_address_b = 16'h0300; bus.pmem_wdata_b = DC;
        @(negedge clk);
        @(negedge clk);
        check("t3_mem_write", 128'(bus.mem_write), 128'(1));
        check("t3_mem_read", 128'(bus.mem_read), 128'(0));
        check("t3_mem_wdata", bus.mem_wdata, DC);
        check("t3_mem_address", 128'(bus.mem_address), 128'(16'h0300));
        wait_resp(10, ra, rb, rdv, cyc);
        check("t3_resp_b", 128'(rb), 128'(1));
        bus.pmem_read_b = 1'b0; bus.pmem_write_b = 1'b0;
        check_log("t3", 1'b1, 16'h0300, 1'b1, DC);

        // a drops its strobe while busy; transaction still completes once
        mem_wait = 2;
        @(negedge clk);
        bus.pmem_read_a = 1'b1; bus.pmem_address_a = 16'h0300;
        @(negedge clk);
        check("t4_busy_read", 128'(bus.mem_read), 128'(1));
        bus.pmem_read_a = 1'b0;
        wait_resp(10, ra, rb, rdv, cyc);
        check("t4_resp_a", 128'(ra), 128'(1));
        check("t4_rdata", rdv, DC);
        @(negedge clk);
        check("t4_after_strobes", 128'({bus.mem_read, bus.mem_write}), 128'(0));
        @(negedge clk);
        check("t4_no_retry", 128'({bus.mem_read, bus.mem_write, bus.pmem_resp_a}), 128'(0));
        check_log("t4", 1'b0, 16'h0300, 1'b0, '0);
        check("t4_one_txn", 128'(log_q.size()), 128'(0));

        // reset while memory read is outstanding, b pending
        mem_wait = 3;
        bus.pmem_read_a = 1'b1; bus.pmem_address_a = 16'h0040;
        @(negedge clk);
        check("t5_busy_read", 128'(bus.mem_read), 128'(1));
        bus.pmem_read_b = 1'b1; bus.pmem_address_b = 16'h0500;
        #2 rst = 1'b1;
        #1 check_idle_outputs("t5_async");
        bus.pmem_read_a = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        wait_resp(12, ra, rb, rdv, cyc);
        check("t5_resp_a", 128'(ra), 128'(0));
        check("t5_resp_b", 128'(rb), 128'(1));
        check("t5_rdata", rdv, pat(16'h0500));
        bus.pmem_read_b = 1'b0;
        check_log("t5", 1'b0, 16'h0500, 1'b0, '0);
        check("t5_one_txn", 128'(log_q.size()), 128'(0));

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
